// File: rtl/braille_msg_ctrl.sv
// braille_msg_ctrl: captures 6-bit Braille cells from the switches into a
// 16-entry message buffer under push-button control and drives a four-digit
// window (last four cells in edit mode, a moving window in scroll mode).
module braille_msg_ctrl #(
  parameter int TICK_DIV  = 25_000_000,
  parameter int DB_CYCLES = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [5:0] SW,
  input  logic [3:0] KEY,
  output logic [5:0] cell0,
  output logic [5:0] cell1,
  output logic [5:0] cell2,
  output logic [5:0] cell3,
  output logic [3:0] blank,
  output logic [4:0] len,
  output logic       full,
  output logic       scrolling
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV + 1) : 1;
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    EDIT   = 1'b0,
    SCROLL = 1'b1
  } state_t;

  // Button synchronizer chain and per-key lockout
  logic [3:0]    s1_r, s2_r, s3_r;
  logic [3:0]    lock_r;
  logic [DW-1:0] db_cnt_r [4];
  logic [3:0]    pulse_s, act_s;
  logic          sto_s, del_s, scr_s, clr_s;

  // Message storage and control state
  logic [5:0]    buf_r [16];
  state_t        state_r, state_n_s;
  logic [4:0]    len_r, len_n_s;
  logic [4:0]    pos_r, pos_n_s;
  logic [TW-1:0] tick_r, tick_n_s;
  logic          wr_en_s;

  // Display window
  logic [4:0]    period_s;
  logic [4:0]    raw_s [4];
  logic [4:0]    idx_s [4];
  logic [5:0]    cell_s [4];
  logic [3:0]    blank_s;

  assign pulse_s = ~s2_r & s3_r;
  assign act_s   = pulse_s & ~lock_r;
  assign sto_s   = act_s[0];
  assign del_s   = act_s[1];
  assign scr_s   = act_s[2];
  assign clr_s   = act_s[3];

  // Bring the asynchronous buttons into the clock domain and keep a history bit
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_r <= 4'hF;
      s2_r <= 4'hF;
      s3_r <= 4'hF;
    end else begin
      s1_r <= KEY;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Lock each key after an accepted press until it has been released long enough
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      lock_r <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!lock_r[i]) begin
          if (pulse_s[i]) begin
            lock_r[i]   <= 1'b1;
            db_cnt_r[i] <= '0;
          end else begin
            db_cnt_r[i] <= '0;
          end
        end else if (!s2_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_LAST) begin
          lock_r[i]   <= 1'b0;
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Command decode and mode transitions; clear > delete > store > scroll
  always_comb begin
    state_n_s = state_r;
    len_n_s   = len_r;
    pos_n_s   = pos_r;
    tick_n_s  = tick_r;
    wr_en_s   = 1'b0;
    case (state_r)
      EDIT: begin
        if (clr_s) begin
          len_n_s = 5'd0;
        end else if (del_s) begin
          if (len_r != 5'd0) begin
            len_n_s = len_r - 5'd1;
          end else begin
            len_n_s = len_r;
          end
        end else if (sto_s) begin
          if (len_r != 5'd16) begin
            wr_en_s = 1'b1;
            len_n_s = len_r + 5'd1;
          end else begin
            wr_en_s = 1'b0;
          end
        end else if (scr_s) begin
          if (len_r != 5'd0) begin
            state_n_s = SCROLL;
            pos_n_s   = 5'd0;
            tick_n_s  = '0;
          end else begin
            state_n_s = EDIT;
          end
        end else begin
          state_n_s = EDIT;
        end
      end
      SCROLL: begin
        if (tick_r == TICK_LAST) begin
          tick_n_s = '0;
          pos_n_s  = (pos_r == len_r + 5'd3) ? 5'd0 : pos_r + 5'd1;
        end else begin
          tick_n_s = tick_r + TW'(1);
        end
        if (clr_s) begin
          len_n_s   = 5'd0;
          state_n_s = EDIT;
        end else if (del_s || sto_s) begin
          state_n_s = SCROLL;
        end else if (scr_s) begin
          state_n_s = EDIT;
        end else begin
          state_n_s = SCROLL;
        end
      end
      default: begin
        state_n_s = EDIT;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= EDIT;
      len_r   <= 5'd0;
      pos_r   <= 5'd0;
      tick_r  <= '0;
    end else begin
      state_r <= state_n_s;
      len_r   <= len_n_s;
      pos_r   <= pos_n_s;
      tick_r  <= tick_n_s;
    end
  end

  // Message buffer write; contents survive reset and clear, only len is reset
  always_ff @(posedge CLOCK_50) begin
    if (wr_en_s) begin
      buf_r[len_r[3:0]] <= SW;
    end
  end

  // Select the four visible cells for the current mode
  always_comb begin
    period_s = len_r + 5'd4;
    blank_s  = 4'hF;
    for (int k = 0; k < 4; k++) begin
      cell_s[k] = 6'd0;
      raw_s[k]  = 5'd0;
      idx_s[k]  = 5'd0;
      if (state_r == SCROLL) begin
        raw_s[k] = pos_r + 5'(3 - k);
        idx_s[k] = (raw_s[k] >= period_s) ? (raw_s[k] - period_s) : raw_s[k];
        if (idx_s[k] < len_r) begin
          cell_s[k]  = buf_r[idx_s[k][3:0]];
          blank_s[k] = 1'b0;
        end else begin
          blank_s[k] = 1'b1;
        end
      end else begin
        if (len_r > 5'(k)) begin
          idx_s[k]   = len_r - 5'(k) - 5'd1;
          cell_s[k]  = buf_r[idx_s[k][3:0]];
          blank_s[k] = 1'b0;
        end else begin
          blank_s[k] = 1'b1;
        end
      end
    end
  end

  // Register every output toward the decoders and the top level
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cell0     <= 6'd0;
      cell1     <= 6'd0;
      cell2     <= 6'd0;
      cell3     <= 6'd0;
      blank     <= 4'hF;
      len       <= 5'd0;
      full      <= 1'b0;
      scrolling <= 1'b0;
    end else begin
      cell0     <= cell_s[0];
      cell1     <= cell_s[1];
      cell2     <= cell_s[2];
      cell3     <= cell_s[3];
      blank     <= blank_s;
      len       <= len_r;
      full      <= (len_r == 5'd16);
      scrolling <= (state_r == SCROLL);
    end
  end

endmodule

// File: tb/tb_braille_msg_ctrl.sv
// Testbench for braille_msg_ctrl: directed scenarios plus randomized button
// sequences, checked against a message-list model of the display.
module tb_braille_msg_ctrl;

  localparam int TICK = 4;
  localparam int DB   = 2;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [5:0] SW       = 6'd0;
  logic [3:0] KEY      = 4'hF;
  logic [5:0] cell0, cell1, cell2, cell3;
  logic [3:0] blank;
  logic [4:0] len;
  logic       full, scrolling;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Reference model: stored message, mode, and the edge on which scrolling began
  logic [5:0] m_buf [16];
  int         m_len    = 0;
  bit         m_scroll = 1'b0;
  int         m_entry  = 0;

  logic [34:0] act;
  logic [34:0] ex;

  braille_msg_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB)) dut (
    .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .SW(SW), .KEY(KEY),
    .cell0(cell0), .cell1(cell1), .cell2(cell2), .cell3(cell3),
    .blank(blank), .len(len), .full(full), .scrolling(scrolling)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edge counter used to time the scroll window
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  assign act = {cell3, cell2, cell1, cell0, blank, len, full, scrolling};

  // Expected outputs as seen just after edge n
  function automatic logic [34:0] exp_out(input int n);
    logic [5:0] c [4];
    logic [3:0] b;
    logic [4:0] l5;
    int p, s;
    b = 4'hF;
    for (int k = 0; k < 4; k++) c[k] = 6'd0;
    if (!m_scroll) begin
      for (int k = 0; k < 4; k++) begin
        if (m_len > k) begin
          c[k] = m_buf[m_len - 1 - k];
          b[k] = 1'b0;
        end
      end
    end else begin
      p = ((n - 1 - m_entry) / TICK) % (m_len + 4);
      for (int k = 0; k < 4; k++) begin
        s = (p + 3 - k) % (m_len + 4);
        if (s < m_len) begin
          c[k] = m_buf[s];
          b[k] = 1'b0;
        end
      end
    end
    l5 = m_len[4:0];
    return {c[3], c[2], c[1], c[0], b, l5, (m_len == 16), m_scroll};
  endfunction

  // Apply one accepted press (possibly several keys) to the model
  function automatic void model_apply(input logic [3:0] mask, input logic [5:0] sw, input int entry);
    if (mask[3]) begin
      m_len = 0;
      m_scroll = 1'b0;
    end else if (mask[1]) begin
      if (!m_scroll && m_len > 0) m_len--;
    end else if (mask[0]) begin
      if (!m_scroll && m_len < 16) begin
        m_buf[m_len] = sw;
        m_len++;
      end
    end else if (mask[2]) begin
      if (m_scroll) m_scroll = 1'b0;
      else if (m_len > 0) begin
        m_scroll = 1'b1;
        m_entry  = entry;
      end
    end
  endfunction

  // Press the keys in mask for one cycle, then release and let lockout expire
  task automatic press(input logic [3:0] mask, input logic [5:0] sw);
    int e1;
    @(negedge CLOCK_50);
    SW  = sw;
    KEY = ~mask;
    e1  = cyc + 1;
    model_apply(mask, sw, e1 + 2);
    @(negedge CLOCK_50);
    KEY = 4'hF;
    repeat (8) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    m_len = 0;
    m_scroll = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex) $display("FAIL reset_values: got %h expected %h", act, ex);
    else passes++;
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if (act !== ex) $display("FAIL reset_idle: got %h expected %h", act, ex);
    else passes++;
  endtask

  task automatic test_store_single;
    logic [34:0] old_v;
    int e1;
    old_v = exp_out(cyc);
    @(negedge CLOCK_50);
    SW  = 6'd3;
    KEY = 4'b1110;
    e1  = cyc + 1;
    model_apply(4'b0001, 6'd3, e1 + 2);
    @(negedge CLOCK_50);
    KEY = 4'hF;
    @(negedge CLOCK_50);
    checks++;
    if (act !== old_v) $display("FAIL store_edge2: got %h expected %h", act, old_v);
    else passes++;
    @(negedge CLOCK_50);
    checks++;
    if (act !== old_v) $display("FAIL store_edge3: got %h expected %h", act, old_v);
    else passes++;
    @(negedge CLOCK_50);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex || cell0 !== 6'd3 || blank !== 4'b1110 || len !== 5'd1)
      $display("FAIL store_edge4: got %h expected %h", act, ex);
    else passes++;
    repeat (6) @(negedge CLOCK_50);
  endtask

  task automatic test_fill_overflow;
    press(4'b1000, 6'd0);
    for (int i = 1; i <= 17; i++) begin
      press(4'b0001, 6'(i));
      ex = exp_out(cyc);
      checks++;
      if (act !== ex) $display("FAIL fill_%0d: got %h expected %h", i, act, ex);
      else passes++;
    end
    checks++;
    if ({cell3, cell2, cell1, cell0, len, full} !== {6'd13, 6'd14, 6'd15, 6'd16, 5'd16, 1'b1})
      $display("FAIL fill_final: got %h expected %h", {cell3, cell2, cell1, cell0, len, full},
               {6'd13, 6'd14, 6'd15, 6'd16, 5'd16, 1'b1});
    else passes++;
  endtask

  task automatic test_delete;
    for (int i = 1; i <= 17; i++) begin
      press(4'b0010, 6'd0);
      ex = exp_out(cyc);
      checks++;
      if (act !== ex) $display("FAIL delete_%0d: got %h expected %h", i, act, ex);
      else passes++;
    end
    checks++;
    if (blank !== 4'hF || len !== 5'd0)
      $display("FAIL delete_empty: got blank=%h len=%0d expected blank=f len=0", blank, len);
    else passes++;
  endtask

  task automatic test_scroll;
    press(4'b0001, 6'd7);
    press(4'b0001, 6'd9);
    press(4'b0001, 6'd11);
    press(4'b0100, 6'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      ex = exp_out(cyc);
      checks++;
      if (act !== ex) $display("FAIL scroll_cyc%0d: got %h expected %h", i, act, ex);
      else passes++;
    end
    press(4'b0100, 6'd0);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex) $display("FAIL scroll_exit: got %h expected %h", act, ex);
    else passes++;
  endtask

  task automatic test_simultaneous;
    press(4'b1000, 6'd0);
    press(4'b0001, 6'd21);
    press(4'b0001, 6'd22);
    press(4'b1001, 6'd23);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex || len !== 5'd0) $display("FAIL clear_beats_store: got %h expected %h", act, ex);
    else passes++;
    press(4'b0100, 6'd0);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex || scrolling !== 1'b0) $display("FAIL scroll_empty: got %h expected %h", act, ex);
    else passes++;
    press(4'b0001, 6'd30);
    press(4'b0011, 6'd31);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex) $display("FAIL delete_beats_store: got %h expected %h", act, ex);
    else passes++;
  endtask

  task automatic test_bounce;
    int e1;
    @(negedge CLOCK_50);
    SW  = 6'd44;
    KEY = 4'b1110;
    e1  = cyc + 1;
    model_apply(4'b0001, 6'd44, e1 + 2);
    @(negedge CLOCK_50);
    KEY = 4'hF;
    @(negedge CLOCK_50);
    KEY = 4'b1110;
    @(negedge CLOCK_50);
    KEY = 4'hF;
    repeat (10) @(negedge CLOCK_50);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex) $display("FAIL bounce_single_store: got %h expected %h", act, ex);
    else passes++;
  endtask

  task automatic test_reset_mid_scroll;
    press(4'b0001, 6'd5);
    press(4'b0100, 6'd0);
    repeat (5) @(negedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    m_len = 0;
    m_scroll = 1'b0;
    #1;
    ex = exp_out(cyc);
    checks++;
    if (act !== ex || scrolling !== 1'b0 || blank !== 4'hF)
      $display("FAIL reset_async: got %h expected %h", act, ex);
    else passes++;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    press(4'b0001, 6'd50);
    ex = exp_out(cyc);
    checks++;
    if (act !== ex) $display("FAIL press_after_reset: got %h expected %h", act, ex);
    else passes++;
  endtask

  task automatic test_random;
    logic [3:0] mask;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      if (r < 5) mask = 4'b0001;
      else if (r < 7) mask = 4'b0010;
      else if (r < 9) mask = 4'b0100;
      else if (r < 10) mask = 4'b1000;
      else mask = 4'($urandom_range(1, 15));
      press(mask, 6'($urandom));
      repeat ($urandom_range(0, 5)) @(negedge CLOCK_50);
      ex = exp_out(cyc);
      checks++;
      if (act !== ex) $display("FAIL random_%0d mask=%b: got %h expected %h", i, mask, act, ex);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_store_single();
    test_fill_overflow();
    test_delete();
    test_scroll();
    test_simultaneous();
    test_bounce();
    test_reset_mid_scroll();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
